countgen_meter: RTL and testbench

- Downstream consumer of the countgen square-wave generator output.
- Synchronises the waveform into the local clock domain and detects its rising and falling edges.
- Measures full period and high time in clk cycles, counts rising edges, and flags loss of signal.
- Delivers each completed measurement over a valid/ready interface to the register/readout stage.

---
 rtl/countgen_pkg.sv | 24 ++
 rtl/countgen_sync.sv | 31 +++
 rtl/countgen_meter.sv | 158 +++++++++++++++
 tb/tb_countgen_meter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countgen_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the countgen generator and its downstream meter.
package countgen_pkg;

  localparam int COUNTGEN_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    if (value >= max_v) begin
      return max_v;
    end else begin
      return value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/countgen_sync.sv
`timescale 1ns/1ps
// Multi-flop synchroniser for an asynchronous level, followed by a history
// flop that turns the synchronised level into single-cycle edge pulses.
module countgen_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Synchroniser shift chain and edge-history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;
  assign fall = ~sync_r[SYNC_STAGES-1] & hist_r;

endmodule

// File: rtl/countgen_meter.sv
`timescale 1ns/1ps
// Measures period and high time of the countgen square wave, counts its rising
// edges, watches for loss of signal and offers results over valid/ready.
module countgen_meter
  import countgen_pkg::*;
#(
  parameter int WIDTH       = COUNTGEN_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] timeout,
  output logic [WIDTH-1:0] meas_period,
  output logic [WIDTH-1:0] meas_high,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [WIDTH-1:0] edge_count,
  output logic             timeout_flag,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  meter_state_t     state_r, state_s;
  logic [WIDTH-1:0] period_cnt_r, period_cnt_s;
  logic [WIDTH-1:0] high_cnt_r, high_cnt_s;
  logic             high_done_r, high_done_s;
  logic [WIDTH-1:0] period_inc_s, high_inc_s, cap_high_s;
  logic             rise_s, fall_s;
  logic             capture_s, timeout_hit_s, timeout_due_s, drop_s;

  countgen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (rise_s),
    .fall     (fall_s)
  );

  // Next-state and counter update; period_cnt doubles as the timeout timer
  always_comb begin
    state_s       = state_r;
    period_cnt_s  = period_cnt_r;
    high_cnt_s    = high_cnt_r;
    high_done_s   = high_done_r;
    capture_s     = 1'b0;
    timeout_hit_s = 1'b0;
    period_inc_s  = WIDTH'(sat_inc(64'(period_cnt_r), WIDTH));
    high_inc_s    = WIDTH'(sat_inc(64'(high_cnt_r), WIDTH));
    cap_high_s    = high_done_r ? high_cnt_r : period_cnt_r;
    timeout_due_s = (timeout != CNT_ZERO) && (period_cnt_r >= timeout);
    if (!enable) begin
      state_s      = IDLE;
      period_cnt_s = CNT_ZERO;
      high_cnt_s   = CNT_ZERO;
      high_done_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s      = ARM;
          period_cnt_s = CNT_ONE;
        end
        ARM: begin
          if (timeout_due_s) begin
            timeout_hit_s = 1'b1;
            period_cnt_s  = CNT_ONE;
          end else if (rise_s) begin
            state_s      = MEASURE;
            period_cnt_s = CNT_ONE;
            high_cnt_s   = CNT_ONE;
            high_done_s  = 1'b0;
          end else begin
            period_cnt_s = period_inc_s;
          end
        end
        MEASURE: begin
          if (timeout_due_s) begin
            timeout_hit_s = 1'b1;
            state_s       = ARM;
            period_cnt_s  = CNT_ONE;
            high_cnt_s    = CNT_ZERO;
            high_done_s   = 1'b0;
          end else if (rise_s) begin
            capture_s    = 1'b1;
            period_cnt_s = CNT_ONE;
            high_cnt_s   = CNT_ONE;
            high_done_s  = 1'b0;
          end else begin
            period_cnt_s = period_inc_s;
            if (high_done_r) begin
              high_cnt_s = high_cnt_r;
            end else if (fall_s) begin
              high_done_s = 1'b1;
            end else begin
              high_cnt_s = high_inc_s;
            end
          end
        end
        default: begin
          state_s      = IDLE;
          period_cnt_s = CNT_ZERO;
          high_cnt_s   = CNT_ZERO;
          high_done_s  = 1'b0;
        end
      endcase
    end
  end

  assign drop_s = capture_s && meas_valid && !meas_ready;

  // FSM state and measurement counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      period_cnt_r <= CNT_ZERO;
      high_cnt_r   <= CNT_ZERO;
      high_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      period_cnt_r <= period_cnt_s;
      high_cnt_r   <= high_cnt_s;
      high_done_r  <= high_done_s;
    end
  end

  // Output register: a stalled consumer keeps the old result, new one is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_period <= CNT_ZERO;
      meas_high   <= CNT_ZERO;
      meas_valid  <= 1'b0;
    end else if (capture_s && !drop_s) begin
      meas_period <= period_cnt_r;
      meas_high   <= cap_high_s;
      meas_valid  <= 1'b1;
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

  // Sticky flags and edge counter; a set event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun      <= 1'b0;
      timeout_flag <= 1'b0;
      edge_count   <= CNT_ZERO;
    end else begin
      overrun      <= drop_s || (overrun && !clear);
      timeout_flag <= timeout_hit_s || (timeout_flag && !clear);
      edge_count   <= (clear ? CNT_ZERO : edge_count) + ((rise_s && enable) ? CNT_ONE : CNT_ZERO);
    end
  end

endmodule

// File: tb/tb_countgen_meter.sv
`timescale 1ns/1ps
// Directed and randomized checks of countgen_meter against a waveform-level
// model built from the times at which the bench drives sig_in edges.
module tb_countgen_meter;

  localparam int W    = 32;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst, sig_in, enable, clear, meas_ready;
  logic [W-1:0] timeout;
  logic [W-1:0] meas_period, meas_high, edge_count;
  logic         meas_valid, timeout_flag, overrun;

  countgen_meter #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .enable       (enable),
    .clear        (clear),
    .timeout      (timeout),
    .meas_period  (meas_period),
    .meas_high    (meas_high),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .edge_count   (edge_count),
    .timeout_flag (timeout_flag),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_p[$];
  int exp_h[$];
  int t_now = 0, rise_t = 0, fall_t = 0, edges_exp = 0;
  bit have_prev = 1'b0, fell = 1'b0, stalled = 1'b0, overrun_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance one clock; any transfer taking place at that edge is scoreboarded.
  task automatic tick();
    logic         xfer;
    logic [W-1:0] p, h;
    xfer = meas_valid & meas_ready;
    p    = meas_period;
    h    = meas_high;
    @(negedge clk);
    t_now++;
    if (xfer === 1'b1) begin
      chk("meas_expected", 64'(exp_p.size() > 0), 64'd1);
      if (exp_p.size() > 0) begin
        chk("meas_period", 64'(p), 64'(exp_p.pop_front()));
        chk("meas_high", 64'(h), 64'(exp_h.pop_front()));
      end
    end
  endtask

  // A rising edge closes the previous cycle: period and high time follow from edge times.
  task automatic drive_rise();
    int p, h;
    if (have_prev) begin
      p = t_now - rise_t;
      h = fell ? (fall_t - rise_t) : p;
      if (stalled && exp_p.size() > 0) begin
        overrun_exp = 1'b1;
      end else begin
        exp_p.push_back(p);
        exp_h.push_back(h);
      end
    end
    have_prev = 1'b1;
    rise_t    = t_now;
    fell      = 1'b0;
    edges_exp++;
    sig_in    = 1'b1;
  endtask

  task automatic drive_fall();
    if (!fell) begin
      fall_t = t_now;
      fell   = 1'b1;
    end
    sig_in = 1'b0;
  endtask

  task automatic gen_cycle(input int h, input int l);
    drive_rise();
    repeat (h) tick();
    drive_fall();
    repeat (l) tick();
  endtask

  task automatic rearm();
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    repeat (2) tick();
    have_prev = 1'b0;
  endtask

  task automatic drain();
    repeat (6) tick();
    chk("queue_drained", 64'(exp_p.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; sig_in = 1'b0; enable = 1'b0; clear = 1'b0;
    meas_ready = 1'b1; timeout = '0;
    repeat (3) tick();
    chk("rst_valid", 64'(meas_valid), 64'd0);
    chk("rst_period", 64'(meas_period), 64'd0);
    chk("rst_high", 64'(meas_high), 64'd0);
    chk("rst_edges", 64'(edge_count), 64'd0);
    chk("rst_timeout", 64'(timeout_flag), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    // Regular 10-cycle wave, high for 5
    rearm();
    repeat (6) gen_cycle(5, 5);
    drain();
    chk("regular_edges", 64'(edge_count), 64'(edges_exp));

    // Random duty and period
    rearm();
    repeat (12) gen_cycle(int'($urandom_range(6, 1)), int'($urandom_range(6, 1)));
    drain();
    chk("random_edges", 64'(edge_count), 64'(edges_exp));

    // Clear on its own
    clear = 1'b1;
    tick();
    clear = 1'b0;
    edges_exp = 0;
    chk("clear_edges", 64'(edge_count), 64'd0);

    // Stalled consumer: first result held, later ones dropped
    meas_ready = 1'b0;
    stalled    = 1'b1;
    rearm();
    repeat (4) gen_cycle(5, 5);
    chk("stall_valid", 64'(meas_valid), 64'd1);
    chk("stall_period", 64'(meas_period), 64'd10);
    chk("stall_high", 64'(meas_high), 64'd5);
    chk("stall_overrun", 64'(overrun), 64'(overrun_exp));
    repeat (3) tick();
    chk("stall_period_stable", 64'(meas_period), 64'd10);
    stalled    = 1'b0;
    meas_ready = 1'b1;
    drain();

    // Loss of signal after a single rising edge
    timeout = 32'd20;
    rearm();
    drive_rise();
    repeat (5) tick();
    drive_fall();
    repeat (SYNC + 20 - 5) tick();
    chk("timeout_not_yet", 64'(timeout_flag), 64'd0);
    tick();
    chk("timeout_flag", 64'(timeout_flag), 64'd1);
    have_prev = 1'b0;
    gen_cycle(5, 5);
    gen_cycle(5, 5);
    drain();
    timeout = '0;
    chk("edges_before_clear", 64'(edge_count), 64'(edges_exp));

    // Clear in the same cycle as a detected rise
    drive_rise();
    repeat (SYNC) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    edges_exp   = 1;
    overrun_exp = 1'b0;
    chk("clear_rise_edges", 64'(edge_count), 64'd1);
    chk("clear_overrun", 64'(overrun), 64'(overrun_exp));
    chk("clear_timeout", 64'(timeout_flag), 64'd0);
    drive_fall();
    drain();

    // Enable dropped mid-period
    rearm();
    drive_rise();
    repeat (SYNC + 1) tick();
    enable    = 1'b0;
    have_prev = 1'b0;
    repeat (3) tick();
    drive_fall();
    repeat (3) tick();
    enable = 1'b1;
    repeat (3) tick();
    gen_cycle(5, 5);
    chk("no_partial_meas", 64'(meas_valid), 64'd0);
    gen_cycle(5, 5);
    gen_cycle(5, 5);
    drain();
    chk("enable_edges", 64'(edge_count), 64'(edges_exp));

    // Reset while a result is waiting and a period is in progress
    meas_ready = 1'b0;
    stalled    = 1'b1;
    rearm();
    gen_cycle(5, 5);
    gen_cycle(4, 3);
    chk("pre_rst_valid", 64'(meas_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(meas_valid), 64'd0);
    chk("mid_rst_period", 64'(meas_period), 64'd0);
    chk("mid_rst_high", 64'(meas_high), 64'd0);
    chk("mid_rst_edges", 64'(edge_count), 64'd0);
    rst = 1'b0;
    exp_p.delete();
    exp_h.delete();
    edges_exp   = 0;
    have_prev   = 1'b0;
    stalled     = 1'b0;
    overrun_exp = 1'b0;
    meas_ready  = 1'b1;

    // Operation after reset
    rearm();
    repeat (3) gen_cycle(int'($urandom_range(5, 2)), int'($urandom_range(5, 2)));
    drain();
    chk("final_edges", 64'(edge_count), 64'(edges_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
